// File: rtl/polar_decoder.sv
// Hard-decision polar decoder.
// A received codeword is loaded into a work register and one butterfly stage
// of the inverse polar transform is applied per clock. The information bits are
// then presented, together with a flag that is set when any frozen position
// decoded to one. Valid/ready handshakes sit on both sides.
module polar_decoder #(
  parameter int             N         = 8,
  parameter int             K         = 4,
  parameter logic [N-1:0]   INFO_MASK = 8'b1110_1000,
  parameter int             LOG2N     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] data_out,
  output logic         frozen_err
);

  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  // Number of set bits in the information mask.
  function automatic int count_ones(input logic [N-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) c++;
    end
    return c;
  endfunction

  // Bit position of the idx-th lowest set bit of the mask.
  function automatic int info_pos(input logic [N-1:0] m, input int idx);
    int c;
    int p;
    c = 0;
    p = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        if (c == idx) p = i;
        c++;
      end
    end
    return p;
  endfunction

  if ((N < 2) || (LOG2N != $clog2(N)) || ((1 << LOG2N) != N)) begin : g_bad_size
    $error("polar_decoder: N must be a power of two >= 2 and LOG2N = log2(N)");
  end

  if (K != count_ones(INFO_MASK)) begin : g_bad_k
    $error("polar_decoder: K must equal the number of ones in INFO_MASK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    u_q, u_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [N-1:0]    bf [LOG2N];

  // Result of each butterfly stage applied to the current work register.
  // Partner index i|span equals i+span whenever bit s of i is clear.
  always_comb begin
    for (int s = 0; s < LOG2N; s++) begin
      for (int i = 0; i < N; i++) begin
        if (((i >> s) & 1) == 0) begin
          bf[s][i] = u_q[i] ^ u_q[i | (1 << s)];
        end else begin
          bf[s][i] = u_q[i];
        end
      end
    end
  end

  // Next-state logic: accept, step through the stages, hold the result.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d     = data_in;
          stage_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (int'(stage_q) >= LOG2N) begin
          // Unreachable stage value: abandon the frame.
          stage_d = '0;
          state_d = IDLE;
        end else begin
          for (int s = 0; s < LOG2N; s++) begin
            if (int'(stage_q) == s) u_d = bf[s];
          end
          stage_d = stage_q + 1'b1;
          if (int'(stage_q) == LOG2N - 1) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, work register and stage counter; cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Gather information bits in ascending position order.
  for (genvar m = 0; m < K; m++) begin : g_info
    assign data_out[m] = u_q[info_pos(INFO_MASK, m)];
  end

  assign frozen_err = |(u_q & ~INFO_MASK);

endmodule

// File: tb/tb_polar_decoder.sv
// Directed and randomised bench for the polar decoder (N=8, K=4, info {3,5,6,7}).
module tb_polar_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic       frozen_err;

  int n_checks;
  int n_fail;

  polar_decoder #(
    .N(8), .K(4), .INFO_MASK(8'b1110_1000), .LOG2N(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .frozen_err(frozen_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Polar encoder reference: x[i] = XOR of u[j] over all j that contain i.
  function automatic logic [7:0] polar_encode(input logic [7:0] u);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) begin
      x[i] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if ((j & i) == i) x[i] = x[i] ^ u[j];
      end
    end
    return x;
  endfunction

  // Drives one frame from IDLE, waits for the result, releases it after gap cycles.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_frame(input logic [7:0] x, input int gap,
                           output logic [3:0] dout, output logic fe,
                           output int lat, output bit tmo);
    in_valid = 1'b1;
    data_in  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = ~x;
    lat = 0;
    tmo = 1'b0;
    while (!out_valid) begin
      if (lat > 20) begin
        tmo = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    dout = data_out;
    fe   = frozen_err;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_checks++;
    if (frozen_err !== 1'b0) begin n_fail++; $display("FAIL reset_frozen_err: got %b want 0", frozen_err); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release_idle: in_ready/out_valid got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_vectors();
    logic [7:0] xs [9];
    logic [3:0] ed [9];
    logic       ef [9];
    logic [3:0] d;
    logic       f;
    int         lat;
    bit         tmo;
    xs[0] = 8'h0F; ed[0] = 4'b0001; ef[0] = 1'b0;
    xs[1] = 8'h96; ed[1] = 4'b1111; ef[1] = 1'b0;
    xs[2] = 8'h00; ed[2] = 4'b0000; ef[2] = 1'b0;
    xs[3] = 8'h01; ed[3] = 4'b0000; ef[3] = 1'b1;
    xs[4] = 8'hFF; ed[4] = 4'b1000; ef[4] = 1'b0;
    xs[5] = 8'h08; ed[5] = 4'b0001; ef[5] = 1'b1;
    xs[6] = 8'h80; ed[6] = 4'b1111; ef[6] = 1'b1;
    xs[7] = 8'hC0; ed[7] = 4'b1011; ef[7] = 1'b1;
    xs[8] = 8'h60; ed[8] = 4'b0110; ef[8] = 1'b1;
    for (int v = 0; v < 9; v++) begin
      run_frame(xs[v], 0, d, f, lat, tmo);
      n_checks++;
      if (tmo || lat != 3) begin
        n_fail++; $display("FAIL vec_latency x=%h: got %0d edges (timeout=%0d) want 3", xs[v], lat, tmo);
      end
      n_checks++;
      if (d !== ed[v]) begin n_fail++; $display("FAIL vec_data x=%h: got %b want %b", xs[v], d, ed[v]); end
      n_checks++;
      if (f !== ef[v]) begin n_fail++; $display("FAIL vec_frozen x=%h: got %b want %b", xs[v], f, ef[v]); end
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++; $display("FAIL vec_return_idle x=%h: in_ready/out_valid got %b want 10", xs[v], {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] d;
    logic       f;
    bit         tmo;
    in_valid = 1'b1;
    data_in  = 8'h96;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL bp_latency: got %0d edges want 3", lat); end
    in_valid = 1'b1;
    data_in  = 8'h0F;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, data_out, frozen_err} !== 7'b1_0_1111_0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid/ready/data/ferr got %b want 1011110",
                 c, {out_valid, in_ready, data_out, frozen_err});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: valid/ready got %b want 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: in_ready got %b want 0", in_ready); end
    lat = 0;
    tmo = 1'b0;
    while (!out_valid) begin
      if (lat > 20) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    d = data_out;
    f = frozen_err;
    n_checks++;
    if (tmo || lat != 3 || d !== 4'b0001 || f !== 1'b0) begin
      n_fail++; $display("FAIL bp_second_frame: lat %0d data %b ferr %b want lat 3 data 0001 ferr 0", lat, d, f);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rises [$];
    int bad_data;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = 8'h96;
    bad_data  = 0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        rises.push_back(c);
        if (data_out !== 4'b1111 || frozen_err !== 1'b0) bad_data++;
      end
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (rises.size() < 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want at least 3", rises.size());
    end else begin
      n_checks++;
      if (rises[1] - rises[0] != 5 || rises[2] - rises[1] != 5) begin
        n_fail++; $display("FAIL b2b_period: got %0d and %0d cycles want 5", rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
    n_checks++;
    if (bad_data != 0) begin n_fail++; $display("FAIL b2b_data: got %0d bad results want 0", bad_data); end
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_idle: in_ready/out_valid got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] d;
    logic       f;
    int         lat;
    bit         tmo;
    in_valid = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, data_out, frozen_err} !== 7'b0_1_0000_0) begin
      n_fail++; $display("FAIL rst_mid_run: valid/ready/data/ferr got %b want 0100000",
                         {out_valid, in_ready, data_out, frozen_err});
    end
    in_valid = 1'b1;
    data_in  = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_run_release: valid/ready got %b want 01", {out_valid, in_ready});
    end
    run_frame(8'h0F, 1, d, f, lat, tmo);
    n_checks++;
    if (tmo || lat != 3 || d !== 4'b0001 || f !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_run_next: lat %0d data %b ferr %b want lat 3 data 0001 ferr 0", lat, d, f);
    end
  endtask

  task automatic test_reset_in_done();
    int lat;
    in_valid = 1'b1;
    data_in  = 8'h80;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if ({out_valid, data_out, frozen_err} !== 6'b1_1111_1) begin
      n_fail++; $display("FAIL rst_done_pre: valid/data/ferr got %b want 111111", {out_valid, data_out, frozen_err});
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, data_out, frozen_err} !== 7'b0_1_0000_0) begin
      n_fail++; $display("FAIL rst_in_done: valid/ready/data/ferr got %b want 0100000",
                         {out_valid, in_ready, data_out, frozen_err});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_done_stays_idle: valid/ready got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_random();
    logic [3:0] info;
    logic [7:0] u;
    logic [3:0] d;
    logic       f;
    int         lat;
    bit         tmo;
    int         errs;
    errs = 0;
    for (int t = 0; t < 1000; t++) begin
      info = 4'($urandom_range(0, 15));
      u = 8'h00;
      u[3] = info[0];
      u[5] = info[1];
      u[6] = info[2];
      u[7] = info[3];
      run_frame(polar_encode(u), $urandom_range(0, 3), d, f, lat, tmo);
      n_checks++;
      if (tmo || lat != 3 || d !== info || f !== 1'b0) begin
        n_fail++;
        errs++;
        if (errs <= 10) begin
          $display("FAIL rand_frame %0d u=%h: lat %0d data %b ferr %b want lat 3 data %b ferr 0",
                   t, u, lat, d, f, info);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_in_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
